// File: rtl/reflet_timer_periph_pkg.sv
// Shared register map and CTRL bit positions for the reflet timer peripheral.
package reflet_timer_periph_pkg;

  typedef enum logic [5:0] {
    TMR_CTRL     = 6'd0,
    TMR_PRESCALE = 6'd1,
    TMR_COMPARE  = 6'd2,
    TMR_COUNT    = 6'd3,
    TMR_STATUS   = 6'd4
  } tmr_reg_e;

  localparam int TMR_RUN      = 0;
  localparam int TMR_PERIODIC = 1;
  localparam int TMR_IRQ_EN   = 2;
  localparam int TMR_CTRL_W   = 3;

endpackage

// File: rtl/reflet_timer_prescaler.sv
// Prescaler for the reflet timer: emits one tick every (prescale+1) enabled, running cycles.
module reflet_timer_prescaler #(
  parameter int wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                run,
  input  logic                clear,
  input  logic [wordsize-1:0] prescale,
  output logic                tick
);

  logic [wordsize-1:0] pcnt;

  assign tick = enable & run & (pcnt == prescale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (enable) begin
      if (clear) begin
        pcnt <= '0;
      end else if (run) begin
        if (pcnt == prescale) pcnt <= '0;
        else                  pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reflet_timer_periph.sv
// Memory-mapped timer for the reflet bus: register file, address decode, registered OR-bus read
// and a prescaled up-counter with compare match and level interrupt.
module reflet_timer_periph
  import reflet_timer_periph_pkg::*;
#(
  parameter int                  wordsize  = 16,
  parameter logic [wordsize-1:0] base_addr = 'hFF00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                irq
);

  localparam int byte_shift = $clog2(wordsize / 8);

  logic [TMR_CTRL_W-1:0] ctrl;
  logic [wordsize-1:0]   prescale;
  logic [wordsize-1:0]   compare;
  logic [wordsize-1:0]   count;
  logic                  match;

  logic                  sel;
  logic [5:0]            idx;
  logic                  wr;
  logic                  wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
  logic                  run_eff;
  logic                  pre_clear;
  logic                  tick;
  logic                  count_hit;
  logic                  match_evt;
  logic [wordsize-1:0]   rd_val;

  assign sel = (addr[wordsize-1:6] == base_addr[wordsize-1:6]);
  assign idx = addr[5:0] >> byte_shift;
  assign wr  = enable & write_en & sel;

  assign wr_ctrl     = wr & (idx == TMR_CTRL);
  assign wr_prescale = wr & (idx == TMR_PRESCALE);
  assign wr_compare  = wr & (idx == TMR_COMPARE);
  assign wr_count    = wr & (idx == TMR_COUNT);
  assign wr_status   = wr & (idx == TMR_STATUS);

  // A write that clears run must suppress the tick of that same edge.
  assign run_eff   = ctrl[TMR_RUN] & ~(wr_ctrl & ~data_in[TMR_RUN]);
  assign pre_clear = wr_prescale | wr_count | (wr_ctrl & data_in[TMR_RUN] & ~ctrl[TMR_RUN]);

  reflet_timer_prescaler #(
    .wordsize (wordsize)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .run      (run_eff),
    .clear    (pre_clear),
    .prescale (prescale),
    .tick     (tick)
  );

  assign count_hit = (count == compare);
  assign match_evt = tick & ~wr_count & count_hit;

  assign irq = match & ctrl[TMR_IRQ_EN];

  always_comb begin
    rd_val = '0;
    case (idx)
      TMR_CTRL:     rd_val = {{(wordsize-TMR_CTRL_W){1'b0}}, ctrl};
      TMR_PRESCALE: rd_val = prescale;
      TMR_COMPARE:  rd_val = compare;
      TMR_COUNT:    rd_val = count;
      TMR_STATUS:   rd_val = {{(wordsize-1){1'b0}}, match};
      default:      rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= '1;
      count    <= '0;
      match    <= 1'b0;
      data_out <= '0;
    end else if (enable) begin
      data_out <= sel ? rd_val : '0;

      if (wr_ctrl)
        ctrl <= data_in[TMR_CTRL_W-1:0];
      else if (match_evt && !ctrl[TMR_PERIODIC])
        ctrl[TMR_RUN] <= 1'b0;

      if (wr_prescale) prescale <= data_in;
      if (wr_compare)  compare  <= data_in;

      if (wr_count)
        count <= data_in;
      else if (tick)
        count <= count_hit ? '0 : count + 1'b1;

      // Hardware set beats a software clear landing on the same edge.
      if (match_evt)
        match <= 1'b1;
      else if (wr_status && data_in[0])
        match <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reflet_timer_periph.sv
// Directed bench for reflet_timer_periph: read expectations go into a scoreboard queue that a
// monitor drains when the registered read data appears.
module tb_reflet_timer_periph;

  localparam logic [15:0] BASE   = 16'hFF00;
  localparam logic [15:0] A_CTRL = 16'hFF00;
  localparam logic [15:0] A_PRE  = 16'hFF02;
  localparam logic [15:0] A_CMP  = 16'hFF04;
  localparam logic [15:0] A_CNT  = 16'hFF06;
  localparam logic [15:0] A_STAT = 16'hFF08;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        write_en;
  logic [15:0] data_out;
  logic        irq;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  logic     rd_req = 1'b0;
  logic     rd_q   = 1'b0;
  int       n_cmp  = 0;
  int       n_bad  = 0;
  int       cycle_no = 0;

  reflet_timer_periph #(
    .wordsize  (16),
    .base_addr (BASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .data_out (data_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: registered read data is valid on the cycle after an enabled read request.
  always @(posedge clk) rd_q <= rd_req & enable;

  always @(negedge clk) begin
    if (rd_q) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        sb_item_t e;
        e = sb.pop_front();
        check(e.name, {16'h0, data_out}, {16'h0, e.exp});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cycle_no++;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; data_in = d; write_en = 1'b1; rd_req = 1'b0;
    cyc();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
    sb_item_t e;
    addr = a; write_en = 1'b0; rd_req = 1'b1;
    e.name = name; e.exp = exp;
    sb.push_back(e);
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic wait_irq(input string name, output int t);
    int n;
    n = 0;
    while (!irq && n < 40) begin
      cyc();
      n++;
    end
    if (!irq) check(name, 0, 1);
    t = cycle_no;
  endtask

  initial begin
    int t0, t1, t2;
    reset = 1'b1; enable = 1'b1; addr = 16'h0; data_in = 16'h0; write_en = 1'b0;
    #12;
    check("reset_data_out", {16'h0, data_out}, 0);
    check("reset_irq", {31'h0, irq}, 0);
    reset = 1'b0;
    cyc();
    rd(A_CMP,  16'hFFFF, "reset_compare");
    rd(A_CTRL, 16'h0000, "reset_ctrl");
    rd(A_CNT,  16'h0000, "reset_count");
    rd(A_STAT, 16'h0000, "reset_status");

    // Periodic: tick every 3 clocks, match on the 4th tick
    wr(A_PRE, 16'd2);
    wr(A_CMP, 16'd3);
    wr(A_CTRL, 16'h0007);
    t0 = cycle_no;
    wait_irq("periodic_irq_timeout_1", t1);
    check("periodic_first_latency", t1 - t0, 12);
    rd(A_CNT,  16'h0000, "periodic_count_wrapped");
    rd(A_STAT, 16'h0001, "periodic_status_set");
    wr(A_STAT, 16'h0001);
    check("periodic_irq_cleared", {31'h0, irq}, 0);
    wait_irq("periodic_irq_timeout_2", t2);
    check("periodic_second_latency", t2 - t1, 12);
    wr(A_CTRL, 16'h0000);
    wr(A_STAT, 16'h0001);
    check("periodic_stop_irq", {31'h0, irq}, 0);

    // One-shot: PRESCALE=0, match on the 2nd tick then run drops
    wr(A_CNT, 16'd0);
    wr(A_CMP, 16'd1);
    wr(A_PRE, 16'd0);
    wr(A_CTRL, 16'h0005);
    t0 = cycle_no;
    wait_irq("oneshot_irq_timeout", t1);
    check("oneshot_latency", t1 - t0, 2);
    rd(A_CTRL, 16'h0004, "oneshot_ctrl_run_cleared");
    rd(A_CNT,  16'h0000, "oneshot_count_zero");
    cyc(); cyc(); cyc();
    rd(A_CNT,  16'h0000, "oneshot_count_stays");
    rd(A_STAT, 16'h0001, "oneshot_status");
    wr(A_STAT, 16'h0001);

    // W1C race: clear on the match edge loses, clear one edge later wins
    wr(A_CNT, 16'd0);
    wr(A_CMP, 16'd3);
    wr(A_CTRL, 16'h0007);
    cyc(); cyc(); cyc();
    wr(A_STAT, 16'h0001);
    check("w1c_race_irq_held", {31'h0, irq}, 1);
    rd(A_STAT, 16'h0001, "w1c_race_status_held");
    wr(A_STAT, 16'h0001);
    check("w1c_late_irq_low", {31'h0, irq}, 0);
    rd(A_STAT, 16'h0000, "w1c_late_status_clear");
    wr(A_CTRL, 16'h0000);
    rd(A_CNT,  16'h0003, "stop_count_holds");
    wr(A_STAT, 16'h0001);
    rd(A_STAT, 16'h0000, "stop_status_clear");

    // Bus decode
    wr(A_PRE, 16'd7);
    wr(A_CMP, 16'h1234);
    rd(A_CMP,          16'h1234, "bus_compare");
    rd(A_PRE,          16'h0007, "bus_prescale");
    rd(BASE + 16'd10,  16'h0000, "bus_unmapped_idx5");
    rd(BASE + 16'h1E,  16'h0000, "bus_unmapped_idx15");
    rd(16'h1004,       16'h0000, "bus_outside_window");
    wr(16'h1004, 16'h5555);
    wr(16'hFE04, 16'h6666);
    rd(A_CMP,          16'h1234, "bus_outside_write_ignored");
    wr(A_CTRL, 16'hFFF8);
    rd(A_CTRL,         16'h0000, "bus_ctrl_masked");

    // Enable freeze: pcnt=1 and COUNT=2 when frozen
    wr(A_PRE, 16'd1);
    wr(A_CMP, 16'd100);
    wr(A_CNT, 16'd0);
    wr(A_CTRL, 16'h0001);
    cyc(); cyc(); cyc(); cyc();
    rd(A_CNT, 16'd2, "freeze_count_before");
    enable = 1'b0;
    cyc();
    addr = A_CNT; data_in = 16'd50; write_en = 1'b1;
    cyc();
    write_en = 1'b0;
    cyc(); cyc(); cyc();
    check("freeze_data_out", {16'h0, data_out}, 2);
    enable = 1'b1;
    rd(A_CNT, 16'd2, "resume_count_0");
    rd(A_CNT, 16'd3, "resume_count_1");
    rd(A_CNT, 16'd3, "resume_count_2");
    rd(A_CNT, 16'd4, "resume_count_3");

    // Asynchronous reset mid-count with irq high and data_out non-zero
    wr(A_CTRL, 16'h0000);
    wr(A_PRE, 16'd0);
    wr(A_CNT, 16'd0);
    wr(A_CMP, 16'd1);
    wr(A_CTRL, 16'h0007);
    cyc(); cyc(); cyc();
    check("pre_reset_irq", {31'h0, irq}, 1);
    rd(A_CMP, 16'd1, "pre_reset_compare");
    cyc();
    #2 reset = 1'b1;
    #1;
    check("async_reset_data_out", {16'h0, data_out}, 0);
    check("async_reset_irq", {31'h0, irq}, 0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    rd(A_CMP,  16'hFFFF, "post_reset_compare");
    rd(A_CTRL, 16'h0000, "post_reset_ctrl");
    rd(A_CNT,  16'h0000, "post_reset_count");
    rd(A_PRE,  16'h0000, "post_reset_prescale");
    rd(A_STAT, 16'h0000, "post_reset_status");
    cyc(); cyc();
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
